// File: rtl/fp_iter_div.sv
// Iterative floating-point divider: radix-2 restoring, one quotient bit per cycle, flush-to-zero.
// Latency NM+6 cycles from acceptance; single op in flight, result held until out_ready.
// Define FP_ITER_DIV_RNE_EN for round-to-nearest-even; otherwise the quotient is truncated.
module fp_iter_div #(
    parameter int NX = 8,
    parameter int NM = 23,
    parameter int TW = 4,
    localparam int NB = 1 + NX + NM
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NB-1:0] in_a,
    input  logic [NB-1:0] in_b,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NB-1:0] out_q,
    output logic [TW-1:0] out_tag,
    output logic [3:0]    out_flags
);

    localparam int EW     = NX + 2;
    localparam int CW     = $clog2(NM + 3);
    localparam int BIAS_I = (1 << (NX - 1)) - 1;
    localparam int EMAX_I = (1 << NX) - 1;

    localparam logic signed [EW-1:0] BIAS      = EW'(BIAS_I);
    localparam logic signed [EW-1:0] EMAX      = EW'(EMAX_I);
    localparam logic [CW-1:0]        ITER_LAST = CW'(NM + 2);
    localparam logic [NB-1:0]        QNAN      = {1'b0, {NX{1'b1}}, 1'b1, {(NM-1){1'b0}}};
    localparam logic [NB-2:0]        INF_MAG   = {{NX{1'b1}}, {NM{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_NORM,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [NB-1:0]        r_a;
    logic [NB-1:0]        r_b;
    logic [TW-1:0]        r_tag;
    logic                 r_sign;
    logic signed [EW-1:0] r_exp;
    logic [NM+1:0]        r_rem;
    logic [NM:0]          r_div;
    logic [NM+2:0]        r_quo;
    logic [CW-1:0]        r_cnt;
    logic                 r_spec;
    logic [NB-1:0]        r_spec_q;
    logic [3:0]           r_spec_flags;
    logic [NB-1:0]        r_out_q;
    logic [TW-1:0]        r_out_tag;
    logic [3:0]           r_out_flags;

    // ---------------- control ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_next = S_PREP;
            S_PREP: w_next = S_ITER;
            S_ITER: if (r_cnt == ITER_LAST) w_next = S_NORM;
            S_NORM: w_next = S_DONE;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_q     = r_out_q;
    assign out_tag   = r_out_tag;
    assign out_flags = r_out_flags;

    // ---------------- unpack / classify ----------------
    logic          w_sa, w_sb, w_sgn;
    logic [NX-1:0] w_ea, w_eb;
    logic [NM-1:0] w_fa, w_fb;
    logic          w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic [NM:0]   w_ma, w_mb;
    logic          w_ma_lt;

    assign w_sa  = r_a[NB-1];
    assign w_sb  = r_b[NB-1];
    assign w_sgn = w_sa ^ w_sb;
    assign w_ea  = r_a[NB-2:NM];
    assign w_eb  = r_b[NB-2:NM];
    assign w_fa  = r_a[NM-1:0];
    assign w_fb  = r_b[NM-1:0];

    // A zero exponent means zero: subnormals are flushed regardless of mantissa.
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (&w_ea) && (w_fa == '0);
    assign w_b_inf  = (&w_eb) && (w_fb == '0);
    assign w_a_nan  = (&w_ea) && (w_fa != '0);
    assign w_b_nan  = (&w_eb) && (w_fb != '0);

    assign w_ma    = {1'b1, w_fa};
    assign w_mb    = {1'b1, w_fb};
    assign w_ma_lt = (w_ma < w_mb);

    // Pre-shifting the dividend keeps the quotient in [1,2), so the first bit is always the hidden one.
    logic signed [EW-1:0] w_exp_pre;
    logic [NM+1:0]        w_rem0;

    assign w_exp_pre = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + BIAS
                     - $signed({{(EW-1){1'b0}}, w_ma_lt});
    assign w_rem0    = w_ma_lt ? {w_ma, 1'b0} : {1'b0, w_ma};

    logic          w_spec;
    logic [NB-1:0] w_spec_q;
    logic [3:0]    w_spec_flags;

    always_comb begin
        w_spec       = 1'b1;
        w_spec_q     = '0;
        w_spec_flags = 4'b0000;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_q     = QNAN;
            w_spec_flags = 4'b0001;
        end else if (w_a_inf) begin
            w_spec_q = {w_sgn, INF_MAG};
        end else if (w_b_zero) begin
            w_spec_q     = {w_sgn, INF_MAG};
            w_spec_flags = 4'b0010;
        end else if (w_a_zero || w_b_inf) begin
            w_spec_q = {w_sgn, {(NB-1){1'b0}}};
        end else begin
            w_spec = 1'b0;
        end
    end

    // ---------------- restoring step ----------------
    logic          w_ge;
    logic [NM+1:0] w_sub;
    logic [NM+1:0] w_keep;
    logic [NM+1:0] w_rem_nxt;

    assign w_ge      = (r_rem >= {1'b0, r_div});
    assign w_sub     = r_rem - {1'b0, r_div};
    assign w_keep    = w_ge ? w_sub : r_rem;
    // Remainder stays below twice the divisor, so the bit shifted out is always zero.
    assign w_rem_nxt = w_keep << 1;

    // ---------------- round / normalise ----------------
    logic                 w_rup;
    logic [NM:0]          w_mant;
    logic [NM+1:0]        w_mant_r;
    logic                 w_carry;
    logic [NM-1:0]        w_frac;
    logic signed [EW-1:0] w_exp_r;
    logic                 w_ovf;
    logic                 w_unf;

    assign w_mant = r_quo[NM+2:2];

`ifdef FP_ITER_DIV_RNE_EN
    logic w_sticky;
    assign w_sticky = (r_rem != '0);
    assign w_rup    = r_quo[1] & (r_quo[0] | w_sticky | r_quo[2]);
`else
    assign w_rup = 1'b0;
`endif

    assign w_mant_r = {1'b0, w_mant} + {{(NM+1){1'b0}}, w_rup};
    assign w_carry  = w_mant_r[NM+1];
    assign w_frac   = w_carry ? w_mant_r[NM:1] : w_mant_r[NM-1:0];
    assign w_exp_r  = r_exp + $signed({{(EW-1){1'b0}}, w_carry});
    assign w_ovf    = (w_exp_r >= EMAX);
    assign w_unf    = w_exp_r[EW-1] || (w_exp_r == '0);

    logic [NB-1:0] w_res_q;
    logic [3:0]    w_res_flags;

    always_comb begin
        w_res_q     = {r_sign, w_exp_r[NX-1:0], w_frac};
        w_res_flags = 4'b0000;
        if (r_spec) begin
            w_res_q     = r_spec_q;
            w_res_flags = r_spec_flags;
        end else if (w_ovf) begin
            w_res_q     = {r_sign, INF_MAG};
            w_res_flags = 4'b0100;
        end else if (w_unf) begin
            w_res_q     = {r_sign, {(NB-1){1'b0}}};
            w_res_flags = 4'b1000;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_tag        <= '0;
            r_sign       <= 1'b0;
            r_exp        <= '0;
            r_rem        <= '0;
            r_div        <= '0;
            r_quo        <= '0;
            r_cnt        <= '0;
            r_spec       <= 1'b0;
            r_spec_q     <= '0;
            r_spec_flags <= '0;
            r_out_q      <= '0;
            r_out_tag    <= '0;
            r_out_flags  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a   <= in_a;
                        r_b   <= in_b;
                        r_tag <= in_tag;
                    end
                end
                S_PREP: begin
                    r_sign       <= w_sgn;
                    r_exp        <= w_exp_pre;
                    r_rem        <= w_rem0;
                    r_div        <= w_mb;
                    r_quo        <= '0;
                    r_cnt        <= '0;
                    r_spec       <= w_spec;
                    r_spec_q     <= w_spec_q;
                    r_spec_flags <= w_spec_flags;
                end
                S_ITER: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= {r_quo[NM+1:0], w_ge};
                    r_cnt <= r_cnt + CW'(1);
                end
                S_NORM: begin
                    r_out_q     <= w_res_q;
                    r_out_flags <= w_res_flags;
                    r_out_tag   <= r_tag;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_iter_div.sv
// Directed-vector bench for fp_iter_div (NX=8, NM=23): driver pushes expectations, negedge monitor checks.
module tb_fp_iter_div;

    localparam int LAT = 29;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_q;
    logic [3:0]  out_tag;
    logic [3:0]  out_flags;

    fp_iter_div dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_tag   (out_tag),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] q;
        logic [3:0]  tag;
        logic [3:0]  flags;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    logic prev_vld = 1'b0;

`ifdef FP_ITER_DIV_RNE_EN
    localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
    localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                         input logic [31:0] eq, input logic [3:0] ef, input bit push);
        exp_t e;
        int   k;
        k = 0;
        while (!in_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) begin
            n_chk++;
            n_err++;
            $display("FAIL issue_timeout: in_ready=0 after 200 cycles, required 1");
        end else begin
            in_a     = a;
            in_b     = b;
            in_tag   = tag;
            in_valid = 1'b1;
            if (push) begin
                e.q     = eq;
                e.tag   = tag;
                e.flags = ef;
                e.cyc   = cyc;
                sb.push_back(e);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
        end
    endtask

    // Monitor: first cycle of out_valid checks latency, the handshake cycle checks the payload.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && !prev_vld) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL spurious_valid: out_valid=1 with q=0x%08h, required no result", out_q);
                end else begin
                    chk("latency", 64'(cyc - sb[0].cyc), 64'(LAT));
                end
            end
            if (rst_n && out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_q", 64'(out_q), 64'(e.q));
                chk("out_tag", 64'(out_tag), 64'(e.tag));
                chk("out_flags", 64'(out_flags), 64'(e.flags));
            end
            prev_vld = out_valid;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_outputs", {28'd0, out_q, out_tag, out_flags}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Ordinary results, rounding and signs.
        issue(32'h40C00000, 32'h40000000, 4'd5, 32'h40400000, 4'b0000, 1'b1); // 6/2
        issue(32'h3F800000, 32'h40400000, 4'd1, THIRD,        4'b0000, 1'b1); // 1/3
        issue(32'h41100000, 32'h40400000, 4'd2, 32'h40400000, 4'b0000, 1'b1); // 9/3
        issue(32'hC0C00000, 32'h40000000, 4'd3, 32'hC0400000, 4'b0000, 1'b1); // -6/2
        issue(32'h3F800000, 32'h3F800000, 4'd4, 32'h3F800000, 4'b0000, 1'b1); // 1/1
        // Special operands.
        issue(32'h3F800000, 32'h00000000, 4'd6, 32'h7F800000, 4'b0010, 1'b1); // 1/0
        issue(32'hBF800000, 32'h00000000, 4'd7, 32'hFF800000, 4'b0010, 1'b1); // -1/0
        issue(32'h00000000, 32'h00000000, 4'd8, 32'h7FC00000, 4'b0001, 1'b1); // 0/0
        issue(32'h7FC00001, 32'h3F800000, 4'd9, 32'h7FC00000, 4'b0001, 1'b1); // NaN/1
        issue(32'h7F800000, 32'hFF800000, 4'hA, 32'h7FC00000, 4'b0001, 1'b1); // inf/-inf
        issue(32'hFF800000, 32'h40000000, 4'hB, 32'hFF800000, 4'b0000, 1'b1); // -inf/2
        issue(32'h00000000, 32'hC0000000, 4'hC, 32'h80000000, 4'b0000, 1'b1); // 0/-2
        issue(32'h40400000, 32'h7F800000, 4'hD, 32'h00000000, 4'b0000, 1'b1); // 3/inf
        issue(32'h00400000, 32'h3F800000, 4'hE, 32'h00000000, 4'b0000, 1'b1); // subnormal/1
        // Exponent range boundaries.
        issue(32'h7F000000, 32'h00800000, 4'h1, 32'h7F800000, 4'b0100, 1'b1);
        issue(32'h00800000, 32'h7F000000, 4'h2, 32'h00000000, 4'b1000, 1'b1);
        issue(32'h7F7FFFFF, 32'h3F000000, 4'h3, 32'h7F800000, 4'b0100, 1'b1); // max/0.5
        issue(32'h00800000, 32'h3F800000, 4'h4, 32'h00800000, 4'b0000, 1'b1); // min normal/1
        issue(32'h00800000, 32'h40000000, 4'h5, 32'h00000000, 4'b1000, 1'b1); // min normal/2
        drain();

        // Back-pressure: result must be held and new requests ignored.
        out_ready = 1'b0;
        issue(32'h40C00000, 32'h40000000, 4'd7, 32'h40400000, 4'b0000, 1'b1);
        k = 0;
        while (!out_valid && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        chk("stall_valid_seen", 64'(out_valid), 64'd1);
        in_a     = 32'h3F800000;
        in_b     = 32'h3F800000;
        in_tag   = 4'd9;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall_hold", {22'd0, out_valid, in_ready, out_tag, out_flags, out_q},
                {22'd0, 1'b1, 1'b0, 4'd7, 4'b0000, 32'h40400000});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        drain();

        // Reset mid-operation abandons the result.
        issue(32'h40C00000, 32'h40000000, 4'd2, 32'h0, 4'b0000, 1'b0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_q", 64'(out_q), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("midrst_no_result", 64'(seen), 64'd0);
        issue(32'h40C00000, 32'h40000000, 4'd3, 32'h40400000, 4'b0000, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
